// File: rtl/calc_b_accum_gen_if.sv
// Frame-memory port bundle for the B-frame accumulator.
//   master : accumulator side (issues read/write bursts, receives read words)
//   slave  : memory-controller side
// Signals:
//   o_mem_rd_start / o_mem_wr_start   1-cycle burst start pulses
//   o_mem_rd_addrs / o_mem_wr_addrs   burst base address
//   o_mem_rd_lengths / o_mem_wr_lengths burst length in words
//   o_mem_rd_data_req                 read-word request
//   i_mem_rd_data                     read word, valid the cycle after a request
//   o_mem_wr_data / o_mem_wr_data_vld write word and strobe
interface calc_b_accum_gen_if #(
    parameter int unsigned ADDRS_DW = 21,
    parameter int unsigned DW       = 14
);
    logic                o_mem_rd_start;
    logic [ADDRS_DW-1:0] o_mem_rd_addrs;
    logic [ADDRS_DW-1:0] o_mem_rd_lengths;
    logic                o_mem_rd_data_req;
    logic [DW-1:0]       i_mem_rd_data;
    logic                o_mem_wr_start;
    logic [ADDRS_DW-1:0] o_mem_wr_addrs;
    logic [ADDRS_DW-1:0] o_mem_wr_lengths;
    logic [DW-1:0]       o_mem_wr_data;
    logic                o_mem_wr_data_vld;

    modport master (
        output o_mem_rd_start, o_mem_rd_addrs, o_mem_rd_lengths, o_mem_rd_data_req,
        output o_mem_wr_start, o_mem_wr_addrs, o_mem_wr_lengths, o_mem_wr_data, o_mem_wr_data_vld,
        input  i_mem_rd_data
    );

    modport slave (
        input  o_mem_rd_start, o_mem_rd_addrs, o_mem_rd_lengths, o_mem_rd_data_req,
        input  o_mem_wr_start, o_mem_wr_addrs, o_mem_wr_lengths, o_mem_wr_data, o_mem_wr_data_vld,
        output i_mem_rd_data
    );
endinterface

// File: rtl/calc_b_accum_gen.sv
// NUC background (B) frame builder. Averages 2^N consecutive frames pixel by
// pixel into external frame memory with a streamed read-modify-write (each
// frame contributes round(p / 2^N), saturating), then computes the global
// mean of the final B frame with a serial divider.
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_calc_en                 rising edge requests a run (accepted in IDLE)
//   i_abort                   level; cancels a run in progress
//   i_log2_frames, i_addrs    N and base address, latched at start
//   i_data, i_data_vld, i_data_vs  pixel stream (vs high for whole frame)
//   mem                       frame-memory read/write master bundle
//   o_b_mean_data, o_mean_vld global mean and its update pulse
//   o_frame_err               sticky per run: a frame pixel count != W*H
//   o_calc_busy, o_calc_done, o_calc_abort  run status
module calc_b_accum_gen #(
    parameter int unsigned IMAGE_WIDE_LENGTH = 256,
    parameter int unsigned IMAGE_HIGH_LENGTH = 192,
    parameter int unsigned ADDRS_DW          = 21,
    parameter int unsigned DW                = 14,
    parameter int unsigned MAX_LOG2_FRAMES   = 5
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_calc_en,
    input  logic                i_abort,
    input  logic [2:0]          i_log2_frames,
    input  logic [ADDRS_DW-1:0] i_addrs,
    input  logic [DW-1:0]       i_data,
    input  logic                i_data_vld,
    input  logic                i_data_vs,
    calc_b_accum_gen_if.master  mem,
    output logic [DW-1:0]       o_b_mean_data,
    output logic                o_mean_vld,
    output logic                o_frame_err,
    output logic                o_calc_busy,
    output logic                o_calc_done,
    output logic                o_calc_abort
);
    localparam int unsigned IMG_LEN = IMAGE_WIDE_LENGTH * IMAGE_HIGH_LENGTH;
    localparam int unsigned SW      = DW + $clog2(IMG_LEN);
    localparam int unsigned FCW     = MAX_LOG2_FRAMES + 1;
    localparam int unsigned CW      = $clog2(SW + 1);
    localparam logic [ADDRS_DW-1:0] LEN_A = ADDRS_DW'(IMG_LEN);
    localparam logic [ADDRS_DW:0]   LEN_R = (ADDRS_DW + 1)'(IMG_LEN);

    typedef enum logic [2:0] {S_IDLE, S_ARM, S_FRAME, S_GAP, S_DIV, S_DONE} state_t;
    state_t state;

    logic                cen_d1, cen_d2, vs_d;
    logic [2:0]          nq;
    logic [ADDRS_DW-1:0] addr_q, len_q, pix_cnt;
    logic [FCW-1:0]      fcnt;
    logic                s1_vld, s1_first, s1_last, s2_last;
    logic [DW:0]         s1_pr;
    logic [SW-1:0]       sum_all, div_n;
    logic [ADDRS_DW-1:0] div_r;
    logic [DW-1:0]       div_q;
    logic [CW-1:0]       div_cnt;
    logic                div_loaded;

    logic                start_take, vs_rise, vs_fall, accept, first_frame, last_frame, div_ge;
    logic [2:0]          nq_in;
    logic [FCW-1:0]      frames_tgt;
    logic [DW:0]         rnd, p_r, sum_c;
    logic [ADDRS_DW:0]   div_sh;

    always_comb begin
        start_take  = (state == S_IDLE) && cen_d1 && !cen_d2 && !i_abort;
        vs_rise     = i_data_vs && !vs_d;
        vs_fall     = !i_data_vs && vs_d;
        nq_in       = (i_log2_frames > 3'(MAX_LOG2_FRAMES)) ? 3'(MAX_LOG2_FRAMES) : i_log2_frames;
        frames_tgt  = FCW'(1) << nq;
        first_frame = (fcnt == '0);
        last_frame  = (fcnt == frames_tgt - FCW'(1));
        accept      = (state == S_FRAME) && i_data_vs && i_data_vld;
        rnd         = (nq == 3'd0) ? '0 : ((DW + 1)'(1) << (nq - 3'd1));
        p_r         = ({1'b0, i_data} + rnd) >> nq;
        sum_c       = s1_pr + (s1_first ? '0 : {1'b0, mem.i_mem_rd_data});
        div_sh      = {div_r, div_n[SW-1]};
        div_ge      = (div_sh >= LEN_R);
    end

    assign o_calc_busy           = (state != S_IDLE);
    assign mem.o_mem_rd_data_req = accept && !first_frame;
    assign mem.o_mem_rd_addrs    = addr_q;
    assign mem.o_mem_wr_addrs    = addr_q;
    assign mem.o_mem_rd_lengths  = len_q;
    assign mem.o_mem_wr_lengths  = len_q;

    // Pixel pipeline: rounding stage, then add/saturate into the write register.
    // First/last-frame flags travel with the pixel because fcnt may advance
    // before the tail of a frame leaves the pipeline.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cen_d1                <= 1'b0;
            cen_d2                <= 1'b0;
            vs_d                  <= 1'b0;
            s1_vld                <= 1'b0;
            s1_pr                 <= '0;
            s1_first              <= 1'b0;
            s1_last               <= 1'b0;
            s2_last               <= 1'b0;
            mem.o_mem_wr_data     <= '0;
            mem.o_mem_wr_data_vld <= 1'b0;
            sum_all               <= '0;
        end else begin
            cen_d1 <= i_calc_en;
            cen_d2 <= cen_d1;
            vs_d   <= i_data_vs;
            s1_vld <= accept;
            if (accept) begin
                s1_pr    <= p_r;
                s1_first <= first_frame;
                s1_last  <= last_frame;
            end
            mem.o_mem_wr_data_vld <= s1_vld;
            if (s1_vld) begin
                mem.o_mem_wr_data <= sum_c[DW] ? '1 : sum_c[DW-1:0];
                s2_last           <= s1_last;
            end
            if (start_take)
                sum_all <= '0;
            else if (mem.o_mem_wr_data_vld && s2_last)
                sum_all <= sum_all + SW'(mem.o_mem_wr_data);
        end
    end

    // Control FSM plus the restoring divider for the mean. The divider loads
    // in the first DIV cycle, after the final strobe has reached sum_all.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state              <= S_IDLE;
            nq                 <= '0;
            addr_q             <= '0;
            len_q              <= '0;
            fcnt               <= '0;
            pix_cnt            <= '0;
            o_frame_err        <= 1'b0;
            mem.o_mem_rd_start <= 1'b0;
            mem.o_mem_wr_start <= 1'b0;
            o_calc_done        <= 1'b0;
            o_calc_abort       <= 1'b0;
            o_mean_vld         <= 1'b0;
            o_b_mean_data      <= '0;
            div_n              <= '0;
            div_r              <= '0;
            div_q              <= '0;
            div_cnt            <= '0;
            div_loaded         <= 1'b0;
        end else begin
            mem.o_mem_rd_start <= 1'b0;
            mem.o_mem_wr_start <= 1'b0;
            o_calc_done        <= 1'b0;
            o_calc_abort       <= 1'b0;
            o_mean_vld         <= 1'b0;
            if (state != S_IDLE && i_abort) begin
                state        <= S_IDLE;
                o_calc_abort <= 1'b1;
                div_loaded   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start_take) begin
                        nq          <= nq_in;
                        addr_q      <= i_addrs;
                        len_q       <= LEN_A;
                        fcnt        <= '0;
                        o_frame_err <= 1'b0;
                        div_loaded  <= 1'b0;
                        state       <= S_ARM;
                    end
                    S_ARM: if (vs_rise) begin
                        pix_cnt            <= '0;
                        mem.o_mem_wr_start <= 1'b1;
                        mem.o_mem_rd_start <= !first_frame;
                        state              <= S_FRAME;
                    end
                    S_FRAME: begin
                        if (accept)
                            pix_cnt <= pix_cnt + 1'b1;
                        if (vs_fall) begin
                            fcnt <= fcnt + 1'b1;
                            if (pix_cnt != LEN_A)
                                o_frame_err <= 1'b1;
                            state <= S_GAP;
                        end
                    end
                    S_GAP: if (fcnt == frames_tgt) begin
                        state <= S_DIV;
                    end else if (vs_rise) begin
                        pix_cnt            <= '0;
                        mem.o_mem_wr_start <= 1'b1;
                        mem.o_mem_rd_start <= 1'b1;
                        state              <= S_FRAME;
                    end
                    S_DIV: if (!div_loaded) begin
                        div_n      <= sum_all;
                        div_r      <= '0;
                        div_q      <= '0;
                        div_cnt    <= CW'(SW);
                        div_loaded <= 1'b1;
                    end else if (div_cnt != '0) begin
                        div_n   <= div_n << 1;
                        div_r   <= div_ge ? ADDRS_DW'(div_sh - LEN_R) : div_sh[ADDRS_DW-1:0];
                        div_q   <= {div_q[DW-2:0], div_ge};
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        o_b_mean_data <= div_q;
                        o_mean_vld    <= 1'b1;
                        o_calc_done   <= 1'b1;
                        div_loaded    <= 1'b0;
                        state         <= S_DONE;
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_calc_b_accum_gen.sv
// Directed bench for calc_b_accum_gen on a 4x2 image, with a simple
// frame-memory model behind the memory bundle.
module tb_calc_b_accum_gen;
    localparam int unsigned W = 4, H = 2, AW = 21, DW = 14, LEN = W * H;

    logic i_clk = 1'b0, i_rst_n = 1'b0, i_calc_en = 1'b0, i_abort = 1'b0;
    logic [2:0] i_log2_frames = '0;
    logic [AW-1:0] i_addrs = '0;
    logic [DW-1:0] i_data = '0;
    logic i_data_vld = 1'b0, i_data_vs = 1'b0;
    logic [DW-1:0] o_b_mean_data;
    logic o_mean_vld, o_frame_err, o_calc_busy, o_calc_done, o_calc_abort;

    int checks = 0, failures = 0;
    int n_wr_start = 0, n_rd_start = 0, n_req = 0, n_done = 0, n_abort = 0, n_mean = 0, n_wr_vld = 0;
    logic [DW-1:0] mem [0:LEN-1];
    int unsigned rd_ptr = 0, wr_ptr = 0;

    always #5 i_clk = ~i_clk;

    calc_b_accum_gen_if #(.ADDRS_DW(AW), .DW(DW)) mem_if ();

    calc_b_accum_gen #(
        .IMAGE_WIDE_LENGTH(W), .IMAGE_HIGH_LENGTH(H), .ADDRS_DW(AW), .DW(DW), .MAX_LOG2_FRAMES(5)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_calc_en(i_calc_en), .i_abort(i_abort),
        .i_log2_frames(i_log2_frames), .i_addrs(i_addrs), .i_data(i_data),
        .i_data_vld(i_data_vld), .i_data_vs(i_data_vs), .mem(mem_if),
        .o_b_mean_data(o_b_mean_data), .o_mean_vld(o_mean_vld), .o_frame_err(o_frame_err),
        .o_calc_busy(o_calc_busy), .o_calc_done(o_calc_done), .o_calc_abort(o_calc_abort)
    );

    // Memory read side: word returned the cycle after each request.
    always @(posedge i_clk) begin
        if (mem_if.o_mem_rd_start) rd_ptr = 0;
        if (mem_if.o_mem_rd_data_req) begin
            mem_if.i_mem_rd_data <= mem[rd_ptr % LEN];
            rd_ptr = rd_ptr + 1;
        end
    end

    // Memory write side and event counters, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (mem_if.o_mem_wr_start) wr_ptr = 0;
        if (mem_if.o_mem_wr_data_vld) begin
            mem[wr_ptr % LEN] = mem_if.o_mem_wr_data;
            wr_ptr = wr_ptr + 1;
            n_wr_vld++;
        end
        if (mem_if.o_mem_wr_start) n_wr_start++;
        if (mem_if.o_mem_rd_start) n_rd_start++;
        if (mem_if.o_mem_rd_data_req) n_req++;
        if (o_calc_done) n_done++;
        if (o_calc_abort) n_abort++;
        if (o_mean_vld) n_mean++;
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic start_run(input logic [2:0] n, input logic [AW-1:0] a);
        i_log2_frames = n;
        i_addrs = a;
        i_calc_en = 1'b1;
        repeat (3) tick;
        i_calc_en = 1'b0;
        i_log2_frames = 3'd0;
        i_addrs = '1;
        tick;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input bit ramp, input int unsigned npix);
        i_data_vs = 1'b1;
        tick;
        tick;
        for (int unsigned i = 0; i < LEN; i++) begin
            i_data_vld = (i < npix);
            i_data = ramp ? DW'(i) : base;
            tick;
            if ((i % W) == W - 1) begin
                i_data_vld = 1'b0;
                tick;
                tick;
            end
        end
        i_data_vld = 1'b0;
        tick;
        i_data_vs = 1'b0;
        repeat (4) tick;
    endtask

    task automatic wait_done(input int base, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (n_done != base) begin
                seen = 1'b1;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        i_rst_n = 1'b0;
        repeat (3) tick;
        checks++;
        if ({o_calc_busy, o_calc_done, o_calc_abort, o_mean_vld, o_frame_err,
             mem_if.o_mem_wr_data_vld, mem_if.o_mem_wr_start, mem_if.o_mem_rd_start,
             mem_if.o_mem_rd_data_req} !== '0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0", {o_calc_busy, o_calc_done, o_calc_abort, o_mean_vld, o_frame_err});
        end
        checks++;
        if (o_b_mean_data !== '0 || mem_if.o_mem_rd_lengths !== '0 || mem_if.o_mem_wr_addrs !== '0) begin
            failures++;
            $display("FAIL reset_values mean=%0d len=%0d addr=%0d exp=0", o_b_mean_data, mem_if.o_mem_rd_lengths, mem_if.o_mem_wr_addrs);
        end
        i_rst_n = 1'b1;
        tick;
    endtask

    task automatic test_n0_ramp;
        int s_wr = n_wr_start, s_rd = n_rd_start, s_req = n_req, s_done = n_done, s_mean = n_mean, s_vld = n_wr_vld;
        bit seen;
        start_run(3'd0, 21'h1234);
        checks++;
        if (o_calc_busy !== 1'b1) begin failures++; $display("FAIL t1_busy got=%0d exp=1", o_calc_busy); end
        checks++;
        if (mem_if.o_mem_rd_addrs !== 21'h1234 || mem_if.o_mem_wr_lengths !== AW'(LEN)) begin
            failures++;
            $display("FAIL t1_addr_len addr=%0h len=%0d exp=1234/%0d", mem_if.o_mem_rd_addrs, mem_if.o_mem_wr_lengths, LEN);
        end
        send_frame('0, 1'b1, LEN);
        wait_done(s_done, seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL t1_done got=0 exp=1"); end
        for (int unsigned i = 0; i < LEN; i++) begin
            checks++;
            if (mem[i] !== DW'(i)) begin failures++; $display("FAIL t1_mem[%0d] got=%0d exp=%0d", i, mem[i], i); end
        end
        checks++;
        if (n_req - s_req != 0 || n_rd_start - s_rd != 0 || n_wr_start - s_wr != 1 || n_wr_vld - s_vld != 8) begin
            failures++;
            $display("FAIL t1_counts req=%0d rds=%0d wrs=%0d vld=%0d exp=0/0/1/8",
                     n_req - s_req, n_rd_start - s_rd, n_wr_start - s_wr, n_wr_vld - s_vld);
        end
        checks++;
        if (o_b_mean_data !== 14'd3 || n_mean - s_mean != 1) begin
            failures++;
            $display("FAIL t1_mean got=%0d pulses=%0d exp=3/1", o_b_mean_data, n_mean - s_mean);
        end
        checks++;
        if (o_calc_busy !== 1'b0 || o_frame_err !== 1'b0) begin
            failures++;
            $display("FAIL t1_idle busy=%0d err=%0d exp=0/0", o_calc_busy, o_frame_err);
        end
        repeat (3) tick;
    endtask

    task automatic test_n2_rounding;
        int s_wr = n_wr_start, s_rd = n_rd_start, s_req = n_req, s_done = n_done;
        bit seen;
        start_run(3'd2, 21'h0040);
        send_frame(14'd10, 1'b0, LEN);
        checks++;
        if (mem[0] !== 14'd3) begin failures++; $display("FAIL t2_frame1 got=%0d exp=3", mem[0]); end
        repeat (3) send_frame(14'd10, 1'b0, LEN);
        wait_done(s_done, seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL t2_done got=0 exp=1"); end
        for (int unsigned i = 0; i < LEN; i++) begin
            checks++;
            if (mem[i] !== 14'd12) begin failures++; $display("FAIL t2_mem[%0d] got=%0d exp=12", i, mem[i]); end
        end
        checks++;
        if (n_req - s_req != 24 || n_rd_start - s_rd != 3 || n_wr_start - s_wr != 4) begin
            failures++;
            $display("FAIL t2_counts req=%0d rds=%0d wrs=%0d exp=24/3/4", n_req - s_req, n_rd_start - s_rd, n_wr_start - s_wr);
        end
        checks++;
        if (o_b_mean_data !== 14'd12) begin failures++; $display("FAIL t2_mean got=%0d exp=12", o_b_mean_data); end
        repeat (3) tick;
    endtask

    task automatic test_clamp_n;
        int s_wr = n_wr_start, s_done = n_done;
        bit seen;
        start_run(3'd7, 21'h0100);
        repeat (31) send_frame(14'd32, 1'b0, LEN);
        checks++;
        if (o_calc_busy !== 1'b1 || n_done != s_done) begin
            failures++;
            $display("FAIL t3_after31 busy=%0d done=%0d exp=1/0", o_calc_busy, n_done - s_done);
        end
        send_frame(14'd32, 1'b0, LEN);
        wait_done(s_done, seen);
        checks++;
        if (!seen) begin failures++; $display("FAIL t3_done got=0 exp=1"); end
        checks++;
        if (n_wr_start - s_wr != 32 || mem[5] !== 14'd32 || o_b_mean_data !== 14'd32) begin
            failures++;
            $display("FAIL t3_result wrs=%0d mem=%0d mean=%0d exp=32/32/32", n_wr_start - s_wr, mem[5], o_b_mean_data);
        end
        repeat (3) tick;
    endtask

    task automatic test_saturation;
        int s_done = n_done;
        bit seen;
        start_run(3'd1, 21'h0200);
        send_frame(14'h3FFF, 1'b0, LEN);
        checks++;
        if (mem[2] !== 14'h2000) begin failures++; $display("FAIL t4_frame1 got=%0h exp=2000", mem[2]); end
        send_frame(14'h3FFF, 1'b0, LEN);
        wait_done(s_done, seen);
        checks++;
        if (!seen || mem[7] !== 14'h3FFF) begin failures++; $display("FAIL t4_sat done=%0d got=%0h exp=3fff", seen, mem[7]); end
        checks++;
        if (o_b_mean_data !== 14'h3FFF) begin failures++; $display("FAIL t4_mean got=%0h exp=3fff", o_b_mean_data); end
        repeat (3) tick;
    endtask

    task automatic test_abort;
        int s_done = n_done, s_mean = n_mean, s_abort = n_abort;
        start_run(3'd2, 21'h0300);
        send_frame(14'd10, 1'b0, LEN);
        i_data_vs = 1'b1;
        tick;
        tick;
        for (int i = 0; i < 3; i++) begin
            i_data_vld = 1'b1;
            i_data = 14'd10;
            tick;
        end
        i_data_vld = 1'b0;
        i_abort = 1'b1;
        tick;
        checks++;
        if (o_calc_abort !== 1'b1 || o_calc_busy !== 1'b0) begin
            failures++;
            $display("FAIL t5_abort abort=%0d busy=%0d exp=1/0", o_calc_abort, o_calc_busy);
        end
        i_abort = 1'b0;
        tick;
        checks++;
        if (o_calc_abort !== 1'b0) begin failures++; $display("FAIL t5_pulse got=%0d exp=0", o_calc_abort); end
        i_data_vs = 1'b0;
        repeat (40) tick;
        checks++;
        if (n_done != s_done || n_mean != s_mean || n_abort - s_abort != 1 || o_b_mean_data !== 14'h3FFF) begin
            failures++;
            $display("FAIL t5_after done=%0d mean_vld=%0d aborts=%0d mean=%0h exp=0/0/1/3fff",
                     n_done - s_done, n_mean - s_mean, n_abort - s_abort, o_b_mean_data);
        end
    endtask

    task automatic test_frame_err_and_reset;
        int s_done = n_done;
        bit seen;
        start_run(3'd0, 21'h0400);
        send_frame(14'd8, 1'b0, LEN - 1);
        wait_done(s_done, seen);
        checks++;
        if (!seen || o_frame_err !== 1'b1) begin failures++; $display("FAIL t6_err done=%0d err=%0d exp=1/1", seen, o_frame_err); end
        checks++;
        if (o_b_mean_data !== 14'd7) begin failures++; $display("FAIL t6_mean got=%0d exp=7", o_b_mean_data); end
        repeat (3) tick;
        start_run(3'd1, 21'h0500);
        checks++;
        if (o_frame_err !== 1'b0) begin failures++; $display("FAIL t6_err_clear got=%0d exp=0", o_frame_err); end
        send_frame(14'd8, 1'b0, LEN - 1);
        checks++;
        if (o_frame_err !== 1'b1 || o_calc_busy !== 1'b1) begin
            failures++;
            $display("FAIL t6_midrun err=%0d busy=%0d exp=1/1", o_frame_err, o_calc_busy);
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_calc_busy, o_frame_err, o_calc_done, o_calc_abort, o_mean_vld, mem_if.o_mem_wr_data_vld} !== '0
            || o_b_mean_data !== '0) begin
            failures++;
            $display("FAIL t6_reset flags=%b mean=%0d exp=0/0",
                     {o_calc_busy, o_frame_err, o_calc_done, o_calc_abort, o_mean_vld}, o_b_mean_data);
        end
        tick;
        i_rst_n = 1'b1;
        tick;
    endtask

    initial begin
        test_reset;
        test_n0_ramp;
        test_n2_rounding;
        test_clamp_n;
        test_saturation;
        test_abort;
        test_frame_err_and_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
